mux_n1_handshake: RTL
=====================

Name: mux_n1_handshake

Overview:
- Parametrised N:1 datapath multiplexer, successor to the fixed 32-bit 2:1 select mux.
- Adds a per-input valid/ready handshake and a registered output stage with backpressure.
- Selection is either fixed (`controle`) or round-robin arbitration among valid inputs.
- Sits between multiple producers (register file ports, ALU, memory return) and a single datapath consumer.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must equal ceil(log2(N)), minimum 1.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- entrada  input  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- entrada_valid  input  N  per-channel valid.
- entrada_ready  output  N  per-channel ready; one-hot or zero.
- controle  input  SEL_W  channel select in fixed mode.
- modo  input  1  0 = fixed select, 1 = round-robin.
- saida  output  WIDTH  registered output data.
- saida_canal  output  SEL_W  index of the channel that produced `saida`.
- saida_valid  output  1  output holds valid data.
- saida_ready  input  1  consumer accepts data.

Behaviour:
- Reset (async assert, sync-safe release): `saida`=0, `saida_canal`=0, `saida_valid`=0, rr pointer `ptr`=0.
- Load enable: `load` = !saida_valid | saida_ready. This is a combinational path from `saida_ready` to `entrada_ready`, which is intentional.
- Grant, fixed mode:
  - `grant` = controle, `grant_ok` = entrada_valid[controle].
  - `controle` ≥ N gives `grant_ok`=0; nothing is accepted.
- Grant, round-robin mode:
  - `grant` = first i with entrada_valid[i] set, searching ptr, ptr+1, … wrapping mod N.
  - `grant_ok` = |entrada_valid.
- `entrada_ready[i]` = load & grant_ok & (i == grant); all other bits are 0.
- A transfer on channel g happens when entrada_valid[g] & entrada_ready[g]. On that clock edge:
  - `saida` ← entrada[g], `saida_canal` ← g, `saida_valid` ← 1.
  - In round-robin mode, `ptr` ← (g+1) mod N. In fixed mode `ptr` is unchanged.
- Load enabled with no transfer: `saida_valid` ← 0 and `saida`/`saida_canal` hold their last values.
- Latency: 1 cycle from input handshake to `saida_valid`. Throughput: 1 word/cycle when `saida_ready` is held high.
- Backpressure: while saida_valid & !saida_ready, `saida` and `saida_canal` stay stable and every `entrada_ready` bit is 0.
- Simultaneous drain and fill (saida_valid & saida_ready & a new transfer): the output is replaced in the same edge with no bubble.
- Changing `modo` or `controle` mid-stream affects only the next grant. A held output word is never altered.
- Wrap-around: ptr = N-1 followed by a grant to N-1 sets ptr to 0.
- Reset asserted mid-transfer: the output is cleared immediately (asynchronous). Any in-flight word is lost and the producer must re-present it.

Test Plan:
- Reset: hold reset_n=0 with all inputs valid → saida_valid=0, saida=0, entrada_ready=0. Release reset with saida_ready=1, modo=0, controle=1, entrada[1]=8 → one cycle later saida=8, saida_canal=1.
- Fixed mode, 2-channel regression: N=2. Cycle A: ch0=8, ch1=10, controle=0 → saida=8. Next cycle: ch0=30, ch1=40, controle=1 → saida=40, saida_canal=1.
- Round-robin fairness: N=4, all valid, values 100+i, saida_ready=1 → saida sequence 100,101,102,103,100, saida_canal cycling 0,1,2,3,0.
- Round-robin skip: only channels 1 and 3 valid, ptr=2 → grant order 3,1,3.
- Backpressure: saida_valid=1 with saida_ready=0 for 3 cycles → saida constant, entrada_ready=0. Raise saida_ready with channel 2 valid → old word drained and new word loaded on the same edge.
- Async reset mid-stream: pull reset_n low between clock edges while saida_valid=1 → saida_valid=0 before the next edge, and ptr=0 after release.

Source files
------------

// File: rtl/mux_n1_handshake_if.sv
// Handshake bundle between N producers, the N:1 multiplexer and one consumer.
// master: the side that drives inputs and consumes the output (producers/consumer).
// slave : the multiplexer itself.
interface mux_n1_handshake_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [N*WIDTH-1:0] entrada;
  logic [N-1:0]       entrada_valid;
  logic [N-1:0]       entrada_ready;
  logic [SEL_W-1:0]   controle;
  logic               modo;
  logic [WIDTH-1:0]   saida;
  logic [SEL_W-1:0]   saida_canal;
  logic               saida_valid;
  logic               saida_ready;

  modport master (
    output entrada, entrada_valid, controle, modo, saida_ready,
    input  entrada_ready, saida, saida_canal, saida_valid
  );

  modport slave (
    input  entrada, entrada_valid, controle, modo, saida_ready,
    output entrada_ready, saida, saida_canal, saida_valid
  );
endinterface

// File: rtl/mux_n1_handshake.sv
// N:1 datapath multiplexer with per-channel valid/ready handshake, fixed or
// round-robin channel selection and a single registered output stage that
// honours consumer backpressure. The saida_ready -> entrada_ready path is
// combinational on purpose so a full output stage can drain and refill in one edge.
module mux_n1_handshake #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2   // must be ceil(log2(N)), minimum 1
) (
  input  logic               clock,
  input  logic               reset_n,
  mux_n1_handshake_if.slave  bus
);

  logic               load_s;
  logic               fix_ok_s;
  logic               rr_ok_s;
  logic               grant_ok_s;
  logic               xfer_s;
  logic [SEL_W-1:0]   rr_grant_s;
  logic [SEL_W-1:0]   grant_s;
  logic [WIDTH-1:0]   grant_data_s;
  logic [N-1:0]       ready_s;
  int                 rr_dist_s;
  int                 rr_best_s;

  logic [WIDTH-1:0]   saida_r;
  logic [SEL_W-1:0]   canal_r;
  logic [SEL_W-1:0]   ptr_r;
  logic               valid_r;

  // The output stage can take a word when it is empty or being drained this cycle.
  assign load_s = ~valid_r | bus.saida_ready;

  // Fixed mode: the selected channel must exist and be valid; out-of-range selects grant nothing.
  always_comb begin
    fix_ok_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.controle == SEL_W'(i)) begin
        fix_ok_s = bus.entrada_valid[i];
      end else begin
        fix_ok_s = fix_ok_s;
      end
    end
  end

  // Round-robin: pick the valid channel with the smallest circular distance from ptr.
  always_comb begin
    rr_grant_s = '0;
    rr_best_s  = N;
    rr_dist_s  = 0;
    for (int i = 0; i < N; i++) begin
      if (i >= int'(ptr_r)) begin
        rr_dist_s = i - int'(ptr_r);
      end else begin
        rr_dist_s = i - int'(ptr_r) + N;
      end
      if (bus.entrada_valid[i] && (rr_dist_s < rr_best_s)) begin
        rr_best_s  = rr_dist_s;
        rr_grant_s = SEL_W'(i);
      end else begin
        rr_best_s  = rr_best_s;
      end
    end
    rr_ok_s = (rr_best_s < N);
  end

  // Mode select for the grant and its qualifier.
  always_comb begin
    if (bus.modo) begin
      grant_s    = rr_grant_s;
      grant_ok_s = rr_ok_s;
    end else begin
      grant_s    = bus.controle;
      grant_ok_s = fix_ok_s;
    end
  end

  assign xfer_s = load_s & grant_ok_s;

  // One-hot ready toward the granted producer, forced low while reset is asserted.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < N; i++) begin
      ready_s[i] = reset_n & xfer_s & (grant_s == SEL_W'(i));
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_s == SEL_W'(i)) begin
        grant_data_s = bus.entrada[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Output stage and round-robin pointer; data/channel hold whenever no transfer occurs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      saida_r <= '0;
      canal_r <= '0;
      valid_r <= 1'b0;
      ptr_r   <= '0;
    end else if (xfer_s) begin
      saida_r <= grant_data_s;
      canal_r <= grant_s;
      valid_r <= 1'b1;
      if (bus.modo) begin
        if (grant_s == SEL_W'(N - 1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= grant_s + SEL_W'(1);
        end
      end else begin
        ptr_r <= ptr_r;
      end
    end else if (load_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign bus.entrada_ready = ready_s;
  assign bus.saida         = saida_r;
  assign bus.saida_canal   = canal_r;
  assign bus.saida_valid   = valid_r;

endmodule
